// File: rtl/spi_reg_pkg.sv
// Shared definitions for the SPI register bridge: FSM state encoding, opcode
// bit layout and the default read-timeout / error-byte values.
package spi_reg_pkg;

    localparam int          ADDR_W         = 7;
    localparam int          OPC_WR_BIT     = 7;
    localparam int unsigned RD_TIMEOUT_DEF = 15;
    localparam logic [7:0]  ERR_BYTE_DEF   = 8'hEE;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        WR_DATA = 2'd1,
        RD_WAIT = 2'd2,
        RD_NEXT = 2'd3
    } state_t;

endpackage

// File: rtl/spi_reg_bridge_if.sv
// Byte-stream and register-bus signals of the SPI register bridge.
//   rx_data_valid / rx_byte      : bytes from the SPI slave
//   tx_data_valid / tx_byte      : byte to load into the SPI shifter
//   reg_addr / reg_wdata         : register address and write data
//   reg_wr / reg_rd              : 1-cycle register strobes
//   reg_rdata / reg_rdata_valid  : register read return
//   rd_timeout                   : 1-cycle pulse when a read is never answered
//   busy                         : bridge is inside a frame
// Modport slave is the bridge itself; master is its environment.
interface spi_reg_bridge_if;
    import spi_reg_pkg::*;

    logic              rx_data_valid;
    logic [7:0]        rx_byte;
    logic              tx_data_valid;
    logic [7:0]        tx_byte;
    logic [ADDR_W-1:0] reg_addr;
    logic [7:0]        reg_wdata;
    logic              reg_wr;
    logic              reg_rd;
    logic [7:0]        reg_rdata;
    logic              reg_rdata_valid;
    logic              rd_timeout;
    logic              busy;

    modport slave (
        input  rx_data_valid, rx_byte, reg_rdata, reg_rdata_valid,
        output tx_data_valid, tx_byte, reg_addr, reg_wdata, reg_wr, reg_rd,
               rd_timeout, busy
    );

    modport master (
        output rx_data_valid, rx_byte, reg_rdata, reg_rdata_valid,
        input  tx_data_valid, tx_byte, reg_addr, reg_wdata, reg_wr, reg_rd,
               rd_timeout, busy
    );

endinterface

// File: rtl/sync_2ff.sv
// Two-flop synchroniser for a single asynchronous control input.
//   clk   : destination clock
//   rst_b : asynchronous active-low reset, both flops load RST_VAL
//   d     : asynchronous input
//   q     : synchronised output
module sync_2ff #(
    parameter logic RST_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst_b,
    input  logic d,
    output logic q
);

    logic meta;

    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            meta <= RST_VAL;
            q    <= RST_VAL;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/spi_reg_bridge.sv
// Turns received SPI bytes into register read/write transactions and returns
// read data to the SPI slave for shifting out on MISO.
// Frame: opcode {wr, addr[6:0]} then data bytes (write) or dummy bytes (read);
// bursts auto-increment the address modulo 128.
//   i_sys_clk  : system clock
//   i_rst_b    : asynchronous active-low reset
//   i_spi_cs_b : raw SPI chip select, frames are delimited by its rise
//   bus        : byte stream and register bus (spi_reg_bridge_if.slave)
//
//   state   | meaning
//   --------+-----------------------------------------------------------
//   IDLE    | waiting for an opcode byte
//   WR_DATA | each rx byte is written, address advances after the write
//   RD_WAIT | read issued, waiting for read data or timeout
//   RD_NEXT | read byte handed to the shifter, dummy byte triggers next read
module spi_reg_bridge
    import spi_reg_pkg::*;
#(
    parameter int unsigned RD_TIMEOUT = RD_TIMEOUT_DEF,
    parameter logic [7:0]  ERR_BYTE   = ERR_BYTE_DEF
) (
    input  logic            i_sys_clk,
    input  logic            i_rst_b,
    input  logic            i_spi_cs_b,
    spi_reg_bridge_if.slave bus
);

    localparam logic [7:0] TO_LAST = 8'(RD_TIMEOUT - 1);

    state_t            state, state_nxt;
    logic              cs_b_sync;
    logic [7:0]        to_cnt, to_cnt_nxt;
    logic [ADDR_W-1:0] addr, addr_nxt, addr_cur;
    logic [7:0]        wdata, wdata_nxt;
    logic [7:0]        tx_byte, tx_byte_nxt;
    logic              wr, wr_nxt;
    logic              rd, rd_nxt;
    logic              tx_vld, tx_vld_nxt;
    logic              to_pls, to_pls_nxt;

    sync_2ff #(.RST_VAL(1'b1)) u_cs_sync (
        .clk   (i_sys_clk),
        .rst_b (i_rst_b),
        .d     (i_spi_cs_b),
        .q     (cs_b_sync)
    );

    always_ff @(posedge i_sys_clk or negedge i_rst_b) begin
        if (!i_rst_b) begin
            state   <= IDLE;
            to_cnt  <= '0;
            addr    <= '0;
            wdata   <= '0;
            tx_byte <= '0;
            wr      <= 1'b0;
            rd      <= 1'b0;
            tx_vld  <= 1'b0;
            to_pls  <= 1'b0;
        end else begin
            state   <= state_nxt;
            to_cnt  <= to_cnt_nxt;
            addr    <= addr_nxt;
            wdata   <= wdata_nxt;
            tx_byte <= tx_byte_nxt;
            wr      <= wr_nxt;
            rd      <= rd_nxt;
            tx_vld  <= tx_vld_nxt;
            to_pls  <= to_pls_nxt;
        end
    end

    always_comb begin
        // The write strobe cycle still presents the written address; the
        // increment lands one cycle later, so a byte arriving in that very
        // cycle must already use the advanced address.
        addr_cur    = wr ? addr + 1'b1 : addr;
        state_nxt   = state;
        addr_nxt    = addr_cur;
        to_cnt_nxt  = to_cnt;
        wdata_nxt   = wdata;
        tx_byte_nxt = tx_byte;
        wr_nxt      = 1'b0;
        rd_nxt      = 1'b0;
        tx_vld_nxt  = 1'b0;
        to_pls_nxt  = 1'b0;

        if (cs_b_sync) begin
            state_nxt = IDLE;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.rx_data_valid) begin
                        addr_nxt = bus.rx_byte[ADDR_W-1:0];
                        if (bus.rx_byte[OPC_WR_BIT]) begin
                            state_nxt = WR_DATA;
                        end else begin
                            rd_nxt     = 1'b1;
                            to_cnt_nxt = '0;
                            state_nxt  = RD_WAIT;
                        end
                    end
                end
                WR_DATA: begin
                    if (bus.rx_data_valid) begin
                        wr_nxt    = 1'b1;
                        wdata_nxt = bus.rx_byte;
                    end
                end
                RD_WAIT: begin
                    // Read data wins over a timeout expiring in the same cycle.
                    if (bus.reg_rdata_valid) begin
                        tx_byte_nxt = bus.reg_rdata;
                        tx_vld_nxt  = 1'b1;
                        addr_nxt    = addr_cur + 1'b1;
                        state_nxt   = RD_NEXT;
                    end else if (to_cnt == TO_LAST) begin
                        tx_byte_nxt = ERR_BYTE;
                        tx_vld_nxt  = 1'b1;
                        to_pls_nxt  = 1'b1;
                        addr_nxt    = addr_cur + 1'b1;
                        state_nxt   = RD_NEXT;
                    end else begin
                        to_cnt_nxt = to_cnt + 8'd1;
                    end
                end
                RD_NEXT: begin
                    if (bus.rx_data_valid) begin
                        rd_nxt     = 1'b1;
                        to_cnt_nxt = '0;
                        state_nxt  = RD_WAIT;
                    end
                end
                default: state_nxt = IDLE;
            endcase
        end
    end

    assign bus.tx_data_valid = tx_vld;
    assign bus.tx_byte       = tx_byte;
    assign bus.reg_addr      = addr;
    assign bus.reg_wdata     = wdata;
    assign bus.reg_wr        = wr;
    assign bus.reg_rd        = rd;
    assign bus.rd_timeout    = to_pls;
    assign bus.busy          = (state != IDLE);

endmodule
